// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: FSM encodings and
// the address/data/halt defaults that are common with the CPU model.
package cpu_mem_responder_pkg;

   localparam int         DEF_ADDRSIZE  = 12;
   localparam int         DEF_WIDTH     = 32;
   localparam logic [6:0] DEF_HALT_CODE = 7'd5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_DUMP = 3'd2,
      ST_DONE = 3'd3
   } state_t;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Bundle of host load, CPU data/instruction and dump signals.
// Data words are [0:WIDTH-1], so bit 0 is the MSB.
interface cpu_mem_responder_if
   import cpu_mem_responder_pkg::*;
#(
   parameter int ADDRSIZE = DEF_ADDRSIZE,
   parameter int WIDTH    = DEF_WIDTH
) ();

   logic                ld_we;
   logic                ld_sel;
   logic [ADDRSIZE-1:0] ld_addr;
   logic [0:WIDTH-1]    ld_data;

   logic [ADDRSIZE-1:0] MEM_ADDR;
   logic [0:WIDTH-1]    MEM_OUT;
   logic                MEM_CTRL;
   logic [0:WIDTH-1]    MEM_IN;
   logic [ADDRSIZE-1:0] INS_ADDR;
   logic [0:WIDTH-1]    INS_MEM;
   logic [6:0]          debuger;

   logic                dump_valid;
   logic [ADDRSIZE-1:0] dump_addr;
   logic [0:WIDTH-1]    dump_data;

   modport master (
      output ld_we, ld_sel, ld_addr, ld_data,
      output MEM_ADDR, MEM_OUT, MEM_CTRL, INS_ADDR, debuger,
      input  MEM_IN, INS_MEM, dump_valid, dump_addr, dump_data
   );

   modport slave (
      input  ld_we, ld_sel, ld_addr, ld_data,
      input  MEM_ADDR, MEM_OUT, MEM_CTRL, INS_ADDR, debuger,
      output MEM_IN, INS_MEM, dump_valid, dump_addr, dump_data
   );

endinterface

// File: rtl/cpu_mem_responder_mem_bank_1w1r.sv
// Word array with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module mem_bank_1w1r #(
   parameter int ADDRSIZE = 12,
   parameter int WIDTH    = 32
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDRSIZE-1:0] waddr,
   input  logic [0:WIDTH-1]    wdata,
   input  logic [ADDRSIZE-1:0] raddr,
   output logic [0:WIDTH-1]    rdata
);

   localparam int DEPTH = 1 << ADDRSIZE;

   logic [0:WIDTH-1] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Synthesizable target for the CPU data and instruction ports: host preload
// in IDLE, CPU service in RUN, then a fixed window of data memory dumped.
module cpu_mem_responder
   import cpu_mem_responder_pkg::*;
#(
   parameter int         ADDRSIZE   = DEF_ADDRSIZE,
   parameter int         WIDTH      = DEF_WIDTH,
   parameter logic [6:0] HALT_CODE  = DEF_HALT_CODE,
   parameter int         MAX_CYCLES = 20,
   parameter int         DUMP_WORDS = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   cpu_mem_responder_if.slave   bus,
   output logic                 done,
   output logic                 timeout,
   output logic [2:0]           state
);

   localparam int                  CNT_W     = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [ADDRSIZE-1:0] DUMP_LAST = ADDRSIZE'(DUMP_WORDS - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    run_cnt, run_cnt_d;
   logic [ADDRSIZE-1:0] dump_ptr, dump_ptr_d;
   logic                timeout_q, timeout_d;

   logic                in_idle, in_run, in_dump;
   logic                dram_we, iram_we;
   logic [ADDRSIZE-1:0] dram_waddr, dram_raddr;
   logic [0:WIDTH-1]    dram_wdata, dram_rdata, iram_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         run_cnt   <= '0;
         dump_ptr  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_cnt   <= run_cnt_d;
         dump_ptr  <= dump_ptr_d;
         timeout_q <= timeout_d;
      end
   end

   // A halt code takes priority over the cycle limit, so timeout stays low
   // when both occur in the same cycle.
   always_comb begin
      state_d    = state_q;
      run_cnt_d  = run_cnt;
      dump_ptr_d = dump_ptr;
      timeout_d  = timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               run_cnt_d = '0;
               timeout_d = 1'b0;
            end
         end
         ST_RUN: begin
            run_cnt_d = run_cnt + 1'b1;
            if (bus.debuger == HALT_CODE) begin
               state_d    = ST_DUMP;
               dump_ptr_d = '0;
               timeout_d  = 1'b0;
            end else if (run_cnt == CNT_LAST) begin
               state_d    = ST_DUMP;
               dump_ptr_d = '0;
               timeout_d  = 1'b1;
            end
         end
         ST_DUMP: begin
            if (dump_ptr == DUMP_LAST) begin
               state_d = ST_DONE;
            end else begin
               dump_ptr_d = dump_ptr + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_idle = (state_q == ST_IDLE);
   assign in_run  = (state_q == ST_RUN);
   assign in_dump = (state_q == ST_DUMP);

   // Host load owns the write ports in IDLE, the CPU owns dram in RUN.
   assign dram_we    = (in_idle && bus.ld_we && !bus.ld_sel) || (in_run && bus.MEM_CTRL);
   assign dram_waddr = in_run ? bus.MEM_ADDR : bus.ld_addr;
   assign dram_wdata = in_run ? bus.MEM_OUT  : bus.ld_data;
   assign dram_raddr = in_run ? bus.MEM_ADDR : dump_ptr;
   assign iram_we    = in_idle && bus.ld_we && bus.ld_sel;

   mem_bank_1w1r #(.ADDRSIZE(ADDRSIZE), .WIDTH(WIDTH)) u_dram (
      .clk   (clk),
      .we    (dram_we),
      .waddr (dram_waddr),
      .wdata (dram_wdata),
      .raddr (dram_raddr),
      .rdata (dram_rdata)
   );

   mem_bank_1w1r #(.ADDRSIZE(ADDRSIZE), .WIDTH(WIDTH)) u_iram (
      .clk   (clk),
      .we    (iram_we),
      .waddr (bus.ld_addr),
      .wdata (bus.ld_data),
      .raddr (bus.INS_ADDR),
      .rdata (iram_rdata)
   );

   assign bus.MEM_IN     = in_run  ? dram_rdata : '0;
   assign bus.INS_MEM    = in_run  ? iram_rdata : '0;
   assign bus.dump_valid = in_dump;
   assign bus.dump_addr  = dump_ptr;
   assign bus.dump_data  = in_dump ? dram_rdata : '0;

   assign done    = (state_q == ST_DONE);
   assign timeout = timeout_q;
   assign state   = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder: preload, timeout run,
// CPU write/read, ignored loads, halt-vs-timeout priority and reset mid-dump.
module tb_cpu_mem_responder;

   logic       clk;
   logic       rst;
   logic       start;
   logic       done;
   logic       timeout;
   logic [2:0] state;

   int checks = 0;
   int passes = 0;
   int run_len = 0;
   logic [31:0] dram_exp [10];

   cpu_mem_responder_if #(.ADDRSIZE(12), .WIDTH(32)) bus ();

   cpu_mem_responder #(
      .ADDRSIZE   (12),
      .WIDTH      (32),
      .HALT_CODE  (7'd5),
      .MAX_CYCLES (20),
      .DUMP_WORDS (10)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bus     (bus),
      .done    (done),
      .timeout (timeout),
      .state   (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      if (state == 3'd1) run_len++;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic sel, input logic [11:0] addr, input logic [31:0] data, input logic go);
      bus.ld_we   = 1'b1;
      bus.ld_sel  = sel;
      bus.ld_addr = addr;
      bus.ld_data = data;
      start       = go;
      step();
      bus.ld_we   = 1'b0;
      start       = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      bus.ld_we    = 1'b0;
      bus.ld_sel   = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = '0;
      bus.MEM_ADDR = '0;
      bus.MEM_OUT  = '0;
      bus.MEM_CTRL = 1'b0;
      bus.INS_ADDR = '0;
      bus.debuger  = '0;
      #1;
      checkOutput("reset_state", state, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_timeout", timeout, 0);
      checkOutput("reset_dump_valid", bus.dump_valid, 0);
      checkOutput("reset_dump_addr", bus.dump_addr, 0);
      checkOutput("reset_mem_in", bus.MEM_IN, 0);
      checkOutput("reset_ins_mem", bus.INS_MEM, 0);
      checkOutput("reset_dump_data", bus.dump_data, 0);
      #1 rst = 1'b1;
      step();

      for (int i = 0; i < 10; i++) dram_exp[i] = (i < 4) ? 32'(7 + i) : 32'(100 + i);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 12'(i), 32'hA000_0000 + 32'(i), 1'b0);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 12'(i), dram_exp[i], 1'b0);

      // Instruction and data reads are forced to zero outside RUN.
      bus.INS_ADDR = 12'd0;
      bus.MEM_ADDR = 12'd0;
      #1;
      checkOutput("idle_ins_mem", bus.INS_MEM, 0);
      checkOutput("idle_mem_in", bus.MEM_IN, 0);

      run_len = 0;
      applyStimulus(1'b0, 12'd9, dram_exp[9], 1'b1);
      checkOutput("start_to_run", state, 1);
      checkOutput("run_ins_mem", bus.INS_MEM, 32'hA000_0000);

      bus.MEM_ADDR = 12'd3;
      bus.MEM_OUT  = 32'd42;
      bus.MEM_CTRL = 1'b1;
      #1;
      checkOutput("write_cycle_old", bus.MEM_IN, 10);
      step();
      bus.MEM_CTRL = 1'b0;
      #1;
      checkOutput("read_after_write", bus.MEM_IN, 42);
      dram_exp[3] = 32'd42;

      bus.ld_we   = 1'b1;
      bus.ld_sel  = 1'b0;
      bus.ld_addr = 12'd0;
      bus.ld_data = 32'd99;
      step();
      bus.ld_we    = 1'b0;
      bus.MEM_ADDR = 12'd0;
      #1;
      checkOutput("ld_we_ignored_run", bus.MEM_IN, 7);

      for (int i = 0; i < 40 && state == 3'd1; i++) step();
      checkOutput("run_length", run_len, 20);
      checkOutput("timeout_state", state, 2);
      checkOutput("timeout_flag", timeout, 1);

      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("dump_valid_%0d", i), bus.dump_valid, 1);
         checkOutput($sformatf("dump_addr_%0d", i), bus.dump_addr, i);
         checkOutput($sformatf("dump_data_%0d", i), bus.dump_data, dram_exp[i]);
         checkOutput($sformatf("done_low_%0d", i), done, 0);
         step();
      end
      checkOutput("done_state", state, 3);
      checkOutput("done_flag", done, 1);
      checkOutput("done_dump_valid", bus.dump_valid, 0);

      start        = 1'b1;
      bus.MEM_CTRL = 1'b1;
      bus.MEM_ADDR = 12'd1;
      bus.MEM_OUT  = 32'h55;
      #1;
      checkOutput("done_mem_in", bus.MEM_IN, 0);
      step();
      start        = 1'b0;
      bus.MEM_CTRL = 1'b0;
      checkOutput("done_ignores_start", state, 3);

      rst = 1'b0;
      #1;
      checkOutput("async_reset_state", state, 0);
      checkOutput("async_reset_done", done, 0);
      checkOutput("async_reset_timeout", timeout, 0);
      #1 rst = 1'b1;
      step();

      run_len = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      bus.MEM_ADDR = 12'd1;
      #1;
      checkOutput("ctrl_ignored_done", bus.MEM_IN, 8);

      for (int i = 0; i < 40 && run_len < 20; i++) step();
      checkOutput("last_run_cycle", state, 1);
      bus.debuger = 7'd5;
      step();
      bus.debuger = 7'd0;
      checkOutput("halt_vs_timeout_state", state, 2);
      checkOutput("halt_wins_timeout", timeout, 0);
      checkOutput("halt_run_length", run_len, 20);
      checkOutput("halt_dump_addr", bus.dump_addr, 0);
      step();
      step();
      checkOutput("third_dump_addr", bus.dump_addr, 2);
      checkOutput("third_dump_data", bus.dump_data, 9);

      rst = 1'b0;
      #1;
      checkOutput("mid_dump_reset_state", state, 0);
      checkOutput("mid_dump_reset_valid", bus.dump_valid, 0);
      checkOutput("mid_dump_reset_data", bus.dump_data, 0);
      #1 rst = 1'b1;
      step();

      run_len = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      bus.MEM_ADDR = 12'd3;
      bus.INS_ADDR = 12'd1;
      #1;
      checkOutput("rerun_state", state, 1);
      checkOutput("rerun_dram", bus.MEM_IN, 42);
      checkOutput("rerun_iram", bus.INS_MEM, 32'hA000_0001);

      bus.debuger = 7'd5;
      step();
      bus.debuger = 7'd0;
      checkOutput("early_halt_state", state, 2);
      checkOutput("early_halt_timeout", timeout, 0);
      checkOutput("early_halt_run_len", run_len, 1);
      checkOutput("early_halt_dump0", bus.dump_data, 7);

      for (int i = 0; i < 20 && done !== 1'b1; i++) step();
      checkOutput("final_done", done, 1);
      checkOutput("final_state", state, 3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
